// File: rtl/spr_pkg.sv
// Shared types and the CA[9:0] address permutation for the sprite-ROM server.
package spr_pkg;

  typedef logic [2:0] decode_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REQ,
    ST_WAIT
  } spr_state_t;

  localparam int CA_W  = 18;
  localparam int DA_W  = 18;
  localparam int SDR_W = 25;

  // CA[3] is not part of the permutation; it is appended below the permuted bits by the caller.
  function automatic logic [8:0] spr_permute(input decode_mode_t mode, input logic [9:0] ca);
    logic [8:0] p;
    unique case (mode)
      3'd0:       p = {ca[9], ca[8], ca[7], ca[6], ca[5], ca[4], ca[2], ca[1], ca[0]};
      3'd1:       p = {ca[9], ca[8], ca[7], ca[5], ca[6], ca[4], ca[2], ca[1], ca[0]};
      3'd2, 3'd3: p = {ca[9], ca[8], ca[7], ca[6], ca[4], ca[2], ca[1], ca[0], ca[5]};
      3'd4:       p = {ca[9], ca[7], ca[8], ca[6], ca[4], ca[2], ca[1], ca[0], ca[5]};
      3'd5, 3'd6: p = {ca[9], ca[8], ca[6], ca[4], ca[2], ca[1], ca[0], ca[7], ca[5]};
      3'd7:       p = {ca[8], ca[6], ca[4], ca[2], ca[1], ca[0], ca[9], ca[7], ca[5]};
      default:    p = {ca[9], ca[8], ca[7], ca[6], ca[5], ca[4], ca[2], ca[1], ca[0]};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/spr_dec_prom.sv
// 256x3 decode PROM: synchronous write from the ioctl loader, asynchronous read.
module spr_dec_prom
  import spr_pkg::*;
#(
  parameter logic [8*64-1:0] PROM_INIT = ""
) (
  input  logic       clk_main,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [2:0] din,
  input  logic [7:0] raddr,
  output logic [2:0] mode
);

  logic [2:0] mem [256];
  decode_mode_t rd_mode;

  // Contents come solely from the loader port and survive reset.
  logic unused_init;
  assign unused_init = ^PROM_INIT;

  always_ff @(posedge clk_main) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  assign rd_mode = mem[raddr];
  assign mode    = rd_mode;

endmodule

// File: rtl/spr_rom_server.sv
// Sprite-ROM responder: permutes k051960 CA into an SDRAM word address, fetches
// over req/ack/valid and holds the last word on CD behind a one-entry tag.
module spr_rom_server
  import spr_pkg::*;
#(
  parameter logic [24:0]     ROM_BASE  = 25'h0,
  parameter logic [8*64-1:0] PROM_INIT = ""
) (
  input  logic        clk_main,
  input  logic        nRES,
  input  logic [17:0] CA,
  output logic [31:0] CD,
  output logic        cd_ok,
  input  logic        prom_we,
  input  logic [7:0]  prom_addr,
  input  logic [2:0]  prom_din,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic        sdr_valid,
  input  logic [31:0] sdr_data
);

  spr_state_t   state_reg, state_next;
  logic [17:0]  ca_reg;
  logic [17:0]  tag_reg;
  logic         tag_valid_reg;
  logic [31:0]  cd_reg;
  logic [24:0]  addr_reg;

  decode_mode_t mode;
  logic [17:0]  da;
  logic         miss;
  logic         capture;
  logic         latch_addr;
  logic         fill;

  spr_dec_prom #(
    .PROM_INIT(PROM_INIT)
  ) u_prom (
    .clk_main(clk_main),
    .we      (prom_we),
    .waddr   (prom_addr),
    .din     (prom_din),
    .raddr   (ca_reg[17:10]),
    .mode    (mode)
  );

  // Decode always works from the CA sampled on entry, never the live input.
  assign da   = {ca_reg[17:10], spr_permute(mode, ca_reg[9:0]), ca_reg[3]};
  assign miss = !tag_valid_reg || (CA != tag_reg);

  always_comb begin
    state_next = state_reg;
    sdr_req    = 1'b0;
    capture    = 1'b0;
    latch_addr = 1'b0;
    fill       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (miss) begin
          capture    = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        latch_addr = 1'b1;
        state_next = ST_REQ;
      end
      ST_REQ: begin
        sdr_req = 1'b1;
        if (sdr_ack) begin
          // A valid arriving with the ack completes the fetch in one step.
          fill       = sdr_valid;
          state_next = sdr_valid ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdr_valid) begin
          fill       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (!nRES) begin
      state_reg     <= ST_IDLE;
      ca_reg        <= '0;
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
      cd_reg        <= '0;
      addr_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        ca_reg <= CA;
      end
      if (latch_addr) begin
        addr_reg <= ROM_BASE + {7'd0, da};
      end
      if (fill) begin
        cd_reg        <= sdr_data;
        tag_reg       <= ca_reg;
        tag_valid_reg <= 1'b1;
      end
    end
  end

  assign CD       = cd_reg;
  assign sdr_addr = addr_reg;
  assign cd_ok    = tag_valid_reg && (CA == tag_reg);

endmodule
